// File: rtl/add_pkg.sv
// Shared types and widths for the two-pass 64-bit adder.
package add_pkg;

    localparam int unsigned OP_W    = 64;
    localparam int unsigned SLICE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/add64_seq_adder32.sv
// 32-bit ripple-carry adder slice, reused for both halves of the 64-bit add.
module adder32
    import add_pkg::*;
(
    input  logic [SLICE_W-1:0] in1,
    input  logic [SLICE_W-1:0] in2,
    input  logic               in_carry,
    output logic [SLICE_W-1:0] out,
    output logic               out_carry
);

    logic w_c;

    always_comb begin
        w_c = in_carry;
        out = '0;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            out[i] = in1[i] ^ in2[i] ^ w_c;
            w_c    = (in1[i] & in2[i]) | (w_c & (in1[i] ^ in2[i]));
        end
        out_carry = w_c;
    end

endmodule

// File: rtl/add64_seq.sv
// 64-bit add/subtract computed over two cycles with one shared 32-bit slice,
// valid/ready on both sides.
module add64_seq
    import add_pkg::*;
#(
    parameter bit SUB_EN = 1'b1
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    input  logic            in_sub,
    input  logic            in_carry,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_sum,
    output logic            out_carry,
    output logic            out_zero,
    output logic            out_ovf
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_sub;
    logic                 w_hi;

    logic [OP_W-1:0]      r_a;
    logic [OP_W-1:0]      r_b;
    logic                 r_c0;
    logic                 r_c32;
    logic [SLICE_W-1:0]   r_lo;
    logic [OP_W-1:0]      r_sum;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_out_valid;

    logic [SLICE_W-1:0]   w_in1;
    logic [SLICE_W-1:0]   w_in2;
    logic                 w_cin;
    logic [SLICE_W-1:0]   w_add_out;
    logic                 w_add_co;
    logic [OP_W-1:0]      w_full_sum;

    assign w_sub = SUB_EN ? in_sub : 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and the only combinational handshake output.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = LO;
            end
            LO:   w_state_nxt = HI;
            HI:   w_state_nxt = DONE;
            DONE: begin
                w_in_ready = out_ready;
                if (out_ready) w_state_nxt = in_valid ? LO : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;
    assign in_ready = w_in_ready;

    // Slice operands: low halves in LO, high halves plus inter-half carry in HI.
    assign w_hi  = (r_state == HI);
    assign w_in1 = w_hi ? r_a[OP_W-1:SLICE_W] : r_a[SLICE_W-1:0];
    assign w_in2 = w_hi ? r_b[OP_W-1:SLICE_W] : r_b[SLICE_W-1:0];
    assign w_cin = w_hi ? r_c32 : r_c0;

    adder32 u_adder32 (
        .in1       (w_in1),
        .in2       (w_in2),
        .in_carry  (w_cin),
        .out       (w_add_out),
        .out_carry (w_add_co)
    );

    assign w_full_sum = {w_add_out, r_lo};

    // Operand capture, low-half staging, and result registers (updated only in HI).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_c0        <= 1'b0;
            r_c32       <= 1'b0;
            r_lo        <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= in_a;
                r_b  <= w_sub ? ~in_b : in_b;
                r_c0 <= w_sub ? 1'b1 : in_carry;
            end
            if (r_state == LO) begin
                r_lo  <= w_add_out;
                r_c32 <= w_add_co;
            end
            if (r_state == HI) begin
                r_sum       <= w_full_sum;
                r_carry     <= w_add_co;
                r_zero      <= (w_full_sum == '0);
                r_ovf       <= (r_a[OP_W-1] == r_b[OP_W-1]) && (w_add_out[SLICE_W-1] != r_a[OP_W-1]);
                r_out_valid <= 1'b1;
            end else if (r_state == DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_add64_seq.sv
// Directed checks for add64_seq: latency, flags, backpressure and mid-flight reset.
module tb_add64_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_sub;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_carry;
    logic        out_zero;
    logic        out_ovf;

    int n_pass = 0;
    int n_total = 0;

    add64_seq #(.SUB_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction from IDLE; called #1 after a rising edge with out_ready=0.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cin, input logic [63:0] es,
                          input logic ec, input logic ez, input logic eo);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_sub = sub; in_carry = cin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_vld_n1"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_lo"}, 64'(in_ready), 64'd0);
        step();
        chk({tag, "_vld_n2"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_vld_n3"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"},   out_sum, es);
        chk({tag, "_carry"}, 64'(out_carry), 64'(ec));
        chk({tag, "_zero"},  64'(out_zero), 64'(ez));
        chk({tag, "_ovf"},   64'(out_ovf), 64'(eo));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_vld_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_sum_held"},  out_sum, es);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_carry = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",   out_sum, 64'd0);
        chk("rst_carry", 64'(out_carry), 64'd0);
        chk("rst_zero",  64'(out_zero), 64'd0);
        chk("rst_ovf",   64'(out_ovf), 64'd0);
        rst_n = 1'b1;

        run_op("add_lo_carry", 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0,
               64'h00000001_00000000, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0,
               64'd0, 1'b1, 1'b1, 1'b0);
        run_op("add_ovf", 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0,
               64'h80000000_00000000, 1'b0, 1'b0, 1'b1);
        run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 1'b0,
               64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b0,
               64'd2, 1'b1, 1'b0, 1'b0);
        run_op("sub_cin_ign", 64'd7, 64'd5, 1'b1, 1'b1,
               64'd2, 1'b1, 1'b0, 1'b0);
        run_op("add_cin", 64'd1, 64'd2, 1'b0, 1'b1,
               64'd4, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf", 64'h80000000_00000000, 64'd1, 1'b1, 1'b0,
               64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b1);
        run_op("sub_eq", 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b1, 1'b0,
               64'd0, 1'b1, 1'b1, 1'b0);

        // Backpressure: result 2 held while new operands wait.
        in_a = 64'd1; in_b = 64'd1; in_sub = 1'b0; in_carry = 1'b0; in_valid = 1'b1;
        step();
        in_a = 64'd10; in_b = 64'd20;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_sum",   out_sum, 64'd2);
            chk("bp_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_hs", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b0;
        in_a = 64'd99; in_b = 64'd99;
        chk("bp_vld_n1", 64'(out_valid), 64'd0);
        chk("bp_sum_kept", out_sum, 64'd2);
        step();
        chk("bp_vld_n2", 64'(out_valid), 64'd0);
        step();
        chk("bp_vld_n3", 64'(out_valid), 64'd1);
        chk("bp_sum2", out_sum, 64'd30);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle", 64'(out_valid), 64'd0);

        // Reset asserted while in HI.
        in_a = 64'hFFFFFFFF_FFFFFFFF; in_b = 64'hFFFFFFFF_FFFFFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rstHI_valid", 64'(out_valid), 64'd0);
        chk("rstHI_sum",   out_sum, 64'd0);
        chk("rstHI_carry", 64'(out_carry), 64'd0);
        chk("rstHI_zero",  64'(out_zero), 64'd0);
        chk("rstHI_ovf",   64'(out_ovf), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rstHI_no_stale", 64'(out_valid), 64'd0);
            step();
        end
        run_op("post_rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
